// File: rtl/lagarto_pmu_pkg.sv
// Shared constants for the Lagarto PMU counter bank: register map, CTRL bits, event names.
package lagarto_pmu_pkg;

    localparam logic [7:0] PMU_CTRL_ADDR  = 8'h00;
    localparam logic [7:0] PMU_OVF_ADDR   = 8'h01;
    localparam logic [7:0] PMU_IRQEN_ADDR = 8'h02;
    localparam logic [7:0] PMU_EVSEL_BASE = 8'h10;
    localparam logic [7:0] PMU_CNT_BASE   = 8'h20;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;
    localparam int unsigned CTRL_FRZ_BIT = 2;

    localparam int unsigned EVSEL_W = 5;

    typedef enum logic [EVSEL_W-1:0] {
        CYCLE        = 5'd0,
        NEW_INSTR    = 5'd1,
        IS_BRANCH    = 5'd2,
        BRANCH_TAKEN = 5'd3,
        BRANCH_MISS  = 5'd4,
        STALL_IF     = 5'd5,
        STALL_ID     = 5'd6,
        STALL_RR     = 5'd7,
        STALL_EXE    = 5'd8,
        STALL_WB     = 5'd9,
        EXE_STORE    = 5'd10,
        EXE_LOAD     = 5'd11,
        DCACHE_REQ   = 5'd12,
        DCACHE_MISS  = 5'd13,
        DMISS_L2HIT  = 5'd14,
        ICACHE_REQ   = 5'd15,
        ICACHE_MISS  = 5'd16,
        IMISS_L2HIT  = 5'd17,
        DTLB_MISS    = 5'd18,
        ITLB_MISS    = 5'd19
    } pmu_evt_e;

endpackage

// File: rtl/lagarto_pmu_counter.sv
// One PMU counter slice: event select register, event mux, wrapping increment and
// clear > write > increment priority.
module lagarto_pmu_counter
    import lagarto_pmu_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = 23,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_l,
    input  logic [NUM_EVENTS-1:0] ev_q_i,
    input  logic                  count_en_i,
    input  logic                  clr_i,
    input  logic                  evsel_we_i,
    input  logic                  cnt_we_i,
    input  logic [EVSEL_W-1:0]    evsel_wdata_i,
    input  logic [CNT_WIDTH-1:0]  cnt_wdata_i,
    output logic [EVSEL_W-1:0]    evsel_o,
    output logic [CNT_WIDTH-1:0]  cnt_o,
    output logic                  wrap_o
);

    logic [EVSEL_W-1:0]   evsel_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ev_hit, inc;

    // Out-of-range selects match no event, so the counter stays idle.
    always_comb begin
        ev_hit = 1'b0;
        for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
            if (evsel_q == EVSEL_W'(k)) ev_hit = ev_q_i[k];
        end
    end

    assign inc    = count_en_i & ev_hit;
    assign wrap_o = inc & (&cnt_q) & ~clr_i & ~cnt_we_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)         cnt_d = '0;
        else if (cnt_we_i) cnt_d = cnt_wdata_i;
        else if (inc)      cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            evsel_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (evsel_we_i) evsel_q <= evsel_wdata_i;
            cnt_q <= cnt_d;
        end
    end

    assign evsel_o = evsel_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/lagarto_pmu_counters.sv
// Lagarto PMU counter bank with word-addressed register port.
// Define LAGARTO_PMU_OVF_IRQ_EN to build IRQEN and the overflow interrupt.
module lagarto_pmu_counters
    import lagarto_pmu_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = 23,
    parameter int unsigned NUM_CNT    = 8,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_l,
    input  logic [NUM_EVENTS-1:0] ev_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [7:0]            addr_i,
    input  logic [63:0]           wdata_i,
    output logic                  ack_o,
    output logic [63:0]           rdata_o,
    output logic                  ovf_irq_o
);

    logic                  req_q, we_q;
    logic [7:0]            addr_q;
    logic [63:0]           wdata_q;
    logic [NUM_EVENTS-1:0] ev_q;
    logic                  en_q, frz_q;
    logic [NUM_CNT-1:0]    ovf_q, ovf_clr, irqen_rd;
    logic                  ack_q;
    logic [63:0]           rdata_q, rd_val;

    logic                  wr, rd, ctrl_we, ovf_we, clr, count_en;
    logic [NUM_CNT-1:0]    evsel_we, cnt_we, wrap;
    logic [EVSEL_W-1:0]    evsel [NUM_CNT];
    logic [CNT_WIDTH-1:0]  cnt [NUM_CNT];

    // Request stage: accesses are performed one edge after they are sampled.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ev_q    <= '0;
        end else begin
            req_q <= req_i;
            ev_q  <= ev_i;
            if (req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    assign wr       = req_q & we_q;
    assign rd       = req_q & ~we_q;
    assign ctrl_we  = wr & (addr_q == PMU_CTRL_ADDR);
    assign ovf_we   = wr & (addr_q == PMU_OVF_ADDR);
    assign clr      = ctrl_we & wdata_q[CTRL_CLR_BIT];
    assign count_en = en_q & ~frz_q;
    assign ovf_clr  = ovf_we ? wdata_q[NUM_CNT-1:0] : '0;

    always_comb begin
        evsel_we = '0;
        cnt_we   = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            evsel_we[i] = wr & (addr_q == PMU_EVSEL_BASE + 8'(i));
            cnt_we[i]   = wr & (addr_q == PMU_CNT_BASE + 8'(i));
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : gen_cnt
        lagarto_pmu_counter #(
            .NUM_EVENTS (NUM_EVENTS),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_counter (
            .clk_i         (clk_i),
            .reset_l       (reset_l),
            .ev_q_i        (ev_q),
            .count_en_i    (count_en),
            .clr_i         (clr),
            .evsel_we_i    (evsel_we[g]),
            .cnt_we_i      (cnt_we[g]),
            .evsel_wdata_i (wdata_q[EVSEL_W-1:0]),
            .cnt_wdata_i   (wdata_q[CNT_WIDTH-1:0]),
            .evsel_o       (evsel[g]),
            .cnt_o         (cnt[g]),
            .wrap_o        (wrap[g])
        );
    end

    // A new wrap wins over a write-1-to-clear on the same edge.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            en_q  <= 1'b0;
            frz_q <= 1'b0;
            ovf_q <= '0;
        end else begin
            if (ctrl_we) begin
                en_q  <= wdata_q[CTRL_EN_BIT];
                frz_q <= wdata_q[CTRL_FRZ_BIT];
            end
            ovf_q <= (ovf_q & ~ovf_clr) | wrap;
        end
    end

`ifdef LAGARTO_PMU_OVF_IRQ_EN
    logic [NUM_CNT-1:0] irqen_q;
    logic               irq_q;
    logic               irqen_we;

    assign irqen_we = wr & (addr_q == PMU_IRQEN_ADDR);

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            irqen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (irqen_we) irqen_q <= wdata_q[NUM_CNT-1:0];
            irq_q <= |(ovf_q & irqen_q);
        end
    end

    assign irqen_rd  = irqen_q;
    assign ovf_irq_o = irq_q;
`else
    assign irqen_rd  = '0;
    assign ovf_irq_o = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        if (addr_q == PMU_CTRL_ADDR) begin
            rd_val[CTRL_EN_BIT]  = en_q;
            rd_val[CTRL_FRZ_BIT] = frz_q;
        end
        if (addr_q == PMU_OVF_ADDR)   rd_val = 64'(ovf_q);
        if (addr_q == PMU_IRQEN_ADDR) rd_val = 64'(irqen_rd);
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (addr_q == PMU_EVSEL_BASE + 8'(i)) rd_val = 64'(evsel[i]);
            if (addr_q == PMU_CNT_BASE + 8'(i))   rd_val = 64'(cnt[i]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= req_q;
            if (rd) rdata_q <= rd_val;
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_lagarto_pmu_counters.sv
// Self-checking bench for lagarto_pmu_counters: directed register/counter scenarios plus
// randomized event traffic checked against per-counter event tallies.
module tb_lagarto_pmu_counters;

    localparam int unsigned NE = 23;
    localparam int unsigned NC = 8;

    logic          clk_i = 1'b0;
    logic          reset_l = 1'b0;
    logic [NE-1:0] ev_i = '0;
    logic          req_i = 1'b0;
    logic          we_i = 1'b0;
    logic [7:0]    addr_i = '0;
    logic [63:0]   wdata_i = '0;
    logic          ack_o;
    logic [63:0]   rdata_o;
    logic          ovf_irq_o;

    int checks = 0;
    int errors = 0;

    lagarto_pmu_counters #(
        .NUM_EVENTS (NE),
        .NUM_CNT    (NC),
        .CNT_WIDTH  (64)
    ) dut (
        .clk_i     (clk_i),
        .reset_l   (reset_l),
        .ev_i      (ev_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .ack_o     (ack_o),
        .rdata_o   (rdata_o),
        .ovf_irq_o (ovf_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One register access; evp pulses events in the cycle the request is sampled.
    task automatic access(input logic we, input logic [7:0] a, input logic [63:0] wd,
                          input logic [NE-1:0] evp, output logic [63:0] rd);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; ev_i = ev_i | evp;
        @(negedge clk_i);
        req_i = 1'b0; ev_i = ev_i & ~evp;
        check("ack_low_before", {63'd0, ack_o}, 64'd0);
        @(posedge clk_i); #1;
        check($sformatf("ack_%02h", a), {63'd0, ack_o}, 64'd1);
        rd = rdata_o;
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] wd);
        logic [63:0] dummy;
        access(1'b1, a, wd, '0, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [63:0] exp);
        logic [63:0] v;
        access(1'b0, a, 64'd0, '0, v);
        check(tag, v, exp);
    endtask

    task automatic pulse(input int idx);
        @(negedge clk_i); ev_i[idx] = 1'b1;
        @(negedge clk_i); ev_i[idx] = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk_i);
    endtask

    logic [63:0] v, run1;
    logic [4:0]  sel [NC];
    logic [63:0] tally [NC];
    logic [NE-1:0] r;
    logic [7:0]  b2b_addr [4];
    logic [63:0] b2b_exp [4];

    initial begin
        repeat (3) @(negedge clk_i);
        reset_l = 1'b1;

        // Reset state
        for (int i = 0; i < NC; i++) rd_chk($sformatf("reset_cnt%0d", i), 8'h20 + 8'(i), 64'd0);
        rd_chk("reset_ctrl", 8'h00, 64'd0);
        rd_chk("reset_ovf", 8'h01, 64'd0);
        check("reset_irq", {63'd0, ovf_irq_o}, 64'd0);

        // Cycle counting over a 100-cycle enable window, twice
        for (int i = 1; i < NC; i++) wr(8'h10 + 8'(i), 64'd31);
        ev_i[0] = 1'b1;
        for (int run = 0; run < 2; run++) begin
            wr(8'h00, 64'h2);
            wr(8'h00, 64'h1);
            repeat (98) @(posedge clk_i);
            wr(8'h00, 64'h0);
            access(1'b0, 8'h20, 64'd0, '0, v);
            check("cyc_window", {63'd0, (v >= 64'd99 && v <= 64'd101)}, 64'd1);
            if (run == 0) run1 = v;
            else check("cyc_repeatable", v, run1);
            rd_chk("cyc_idle_cnt1", 8'h21, 64'd0);
        end
        ev_i[0] = 1'b0;

        // Freeze holds the count, writes still land
        wr(8'h11, 64'd4);
        wr(8'h00, 64'h3);
        repeat (7) pulse(4);
        wr(8'h00, 64'h5);
        repeat (3) pulse(4);
        repeat (2) @(negedge clk_i);
        rd_chk("frz_cnt1", 8'h21, 64'd7);
        rd_chk("frz_ctrl", 8'h00, 64'h5);
        wr(8'h21, 64'd42);
        rd_chk("frz_write", 8'h21, 64'd42);
        wr(8'h00, 64'h1);

        // Wrap and overflow
        wr(8'h10, 64'd31);
        wr(8'h12, 64'd0);
        wr(8'h22, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk_i); ev_i[0] = 1'b1;
        repeat (3) @(negedge clk_i);
        ev_i[0] = 1'b0;
        repeat (2) @(negedge clk_i);
        rd_chk("wrap_cnt2", 8'h22, 64'd1);
        rd_chk("wrap_ovf", 8'h01, 64'h04);
        wr(8'h02, 64'h04);
        @(posedge clk_i); #1;
`ifdef LAGARTO_PMU_OVF_IRQ_EN
        check("irq_set", {63'd0, ovf_irq_o}, 64'd1);
        rd_chk("irqen_rd", 8'h02, 64'h04);
`else
        check("irq_tied", {63'd0, ovf_irq_o}, 64'd0);
        rd_chk("irqen_rd", 8'h02, 64'h00);
`endif
        wr(8'h22, 64'hFFFF_FFFF_FFFF_FFFF);
        access(1'b1, 8'h01, 64'h04, 23'h1, v);
        rd_chk("ovf_w1c_vs_wrap", 8'h01, 64'h04);
        rd_chk("wrap_cnt2_zero", 8'h22, 64'd0);
        wr(8'h01, 64'h04);
        repeat (2) @(posedge clk_i); #1;
        check("irq_cleared", {63'd0, ovf_irq_o}, 64'd0);
        rd_chk("ovf_cleared", 8'h01, 64'h0);

        // Clear and write priority over increment
        wr(8'h13, 64'd1);
        wr(8'h23, 64'd10);
        access(1'b1, 8'h00, 64'h3, 23'h2, v);
        rd_chk("clr_vs_inc", 8'h23, 64'd0);
        rd_chk("clr_other", 8'h21, 64'd0);
        rd_chk("clr_reads0", 8'h00, 64'h1);
        access(1'b1, 8'h23, 64'd5, 23'h2, v);
        rd_chk("write_vs_inc", 8'h23, 64'd5);
        pulse(1);
        repeat (2) @(negedge clk_i);
        rd_chk("inc_after_write", 8'h23, 64'd6);

        // Back-to-back reads
        b2b_addr[0] = 8'h00; b2b_exp[0] = 64'h1;
        b2b_addr[1] = 8'h01; b2b_exp[1] = 64'h0;
        b2b_addr[2] = 8'h40; b2b_exp[2] = 64'h0;
        b2b_addr[3] = 8'h10; b2b_exp[3] = 64'd31;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            if (k >= 2 && k < 6) begin
                check($sformatf("b2b_ack%0d", k - 2), {63'd0, ack_o}, 64'd1);
                check($sformatf("b2b_data%0d", k - 2), rdata_o, b2b_exp[k-2]);
            end
            if (k == 6) check("b2b_ack_end", {63'd0, ack_o}, 64'd0);
            if (k < 4) begin
                req_i = 1'b1; we_i = 1'b0; addr_i = b2b_addr[k];
            end else begin
                req_i = 1'b0;
            end
        end
        wr(8'h40, 64'hDEAD);
        rd_chk("unmapped_rd", 8'h40, 64'h0);

        // Randomized events against per-counter tallies
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < NC; i++) begin
                sel[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, NE - 1));
                tally[i] = 64'd0;
                wr(8'h10 + 8'(i), 64'(sel[i]));
            end
            wr(8'h00, 64'h3);
            for (int c = 0; c < 200; c++) begin
                @(negedge clk_i);
                r = NE'({$urandom, $urandom});
                ev_i = r;
                for (int i = 0; i < NC; i++)
                    if (sel[i] < 5'(NE) && r[sel[i]]) tally[i] = tally[i] + 64'd1;
            end
            @(negedge clk_i); ev_i = '0;
            wr(8'h00, 64'h0);
            for (int i = 0; i < NC; i++)
                rd_chk($sformatf("rand%0d_cnt%0d", it, i), 8'h20 + 8'(i), tally[i]);
        end

        // Reset during a pending read
        @(negedge clk_i); req_i = 1'b1; we_i = 1'b0; addr_i = 8'h20;
        @(negedge clk_i); req_i = 1'b0; reset_l = 1'b0;
        @(posedge clk_i); #1;
        check("rst_ack_dropped", {63'd0, ack_o}, 64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        @(negedge clk_i); reset_l = 1'b1;
        @(posedge clk_i); #1;
        check("rst_no_late_ack", {63'd0, ack_o}, 64'd0);
        for (int i = 0; i < NC; i++) rd_chk($sformatf("rst_cnt%0d", i), 8'h20 + 8'(i), 64'd0);
        rd_chk("rst_evsel0", 8'h10, 64'd0);
        rd_chk("rst_ctrl", 8'h00, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
